// File: rtl/title_pixel_compositor_pkg.sv
// Shared types and constants for the title compositor: colour struct, pixel
// bundle carried down the pipeline, palette and fade FSM states.
package title_pkg;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef struct packed {
        logic is_obj;
        rgb_t bg;
        logic blank;
        logic hs;
        logic vs;
    } pix_t;

    typedef enum logic [1:0] {
        ST_SHOW,
        ST_BRIGHTEN,
        ST_PLAY
    } fsm_state_e;

    localparam logic [3:0] TRANSPARENT_IDX = 4'd0;

    // Sync lines idle high, so the flushed pipeline shows no sync pulses
    localparam pix_t PIX_RST = '{is_obj: 1'b0, bg: '0, blank: 1'b0, hs: 1'b1, vs: 1'b1};

    localparam rgb_t PALETTE [16] = '{
        24'h000000, 24'hFFFFFF, 24'hFF0000, 24'h00FF00,
        24'h0000FF, 24'hFFD700, 24'hFF8C00, 24'h8A2BE2,
        24'h00CED1, 24'hDC143C, 24'h7FFF00, 24'h1E90FF,
        24'hC0C0C0, 24'h808080, 24'h402010, 24'hF5DEB3
    };

    function automatic rgb_t dim_rgb(input rgb_t c, input logic [2:0] sh);
        rgb_t o;
        o.r = c.r >> sh;
        o.g = c.g >> sh;
        o.b = c.b >> sh;
        return o;
    endfunction

endpackage

// File: rtl/title_pixel_compositor_if.sv
// Pixel/ROM bus between the overlay+background generators, title ROM and VGA DAC.
interface title_pixel_compositor_if #(
    parameter int unsigned ADDR_W = 18
);
    logic              Game_Start_On;
    logic              is_obj;
    logic [ADDR_W-1:0] Obj_address;
    logic [23:0]       Bg_rgb;
    logic              blank_in;
    logic              hs_in;
    logic              vs_in;
    logic [ADDR_W-1:0] rom_addr;
    logic [3:0]        rom_data;
    logic [7:0]        Red;
    logic [7:0]        Green;
    logic [7:0]        Blue;
    logic              blank_out;
    logic              hs_out;
    logic              vs_out;
    logic              Fade_Done;

    modport master (
        output Game_Start_On, is_obj, Obj_address, Bg_rgb, blank_in, hs_in, vs_in, rom_data,
        input  rom_addr, Red, Green, Blue, blank_out, hs_out, vs_out, Fade_Done
    );

    modport slave (
        input  Game_Start_On, is_obj, Obj_address, Bg_rgb, blank_in, hs_in, vs_in, rom_data,
        output rom_addr, Red, Green, Blue, blank_out, hs_out, vs_out, Fade_Done
    );
endinterface

// File: rtl/title_pixel_compositor_sideband_delay.sv
// Fixed-depth shift register with asynchronous reset to a per-bit value.
module sideband_delay #(
    parameter int unsigned       WIDTH   = 1,
    parameter int unsigned       DEPTH   = 1,
    parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] stage_d [DEPTH];
    logic [WIDTH-1:0] stage_q [DEPTH];

    always_comb begin
        stage_d[0] = d;
        for (int unsigned i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stage_q[i] <= RST_VAL;
            end
        end else begin
            stage_q <= stage_d;
        end
    end

    assign q = stage_q[DEPTH-1];
endmodule

// File: rtl/title_pixel_compositor.sv
// Title overlay compositor: ROM fetch, palette lookup, background dim/fade,
// and sideband alignment over a ROM_LAT+2 pixel pipeline.
module title_pixel_compositor
    import title_pkg::*;
#(
    parameter int unsigned ROM_LAT = 2,
    parameter int unsigned ADDR_W  = 18,
    parameter int unsigned BG_DIM  = 2
) (
    input logic                     Clk,
    input logic                     Reset_n,
    title_pixel_compositor_if.slave bus
);
    localparam logic [2:0] DIM_INIT = 3'(BG_DIM);

    logic [ADDR_W-1:0] rom_addr_d, rom_addr_q;
    pix_t              pix_in, pix_dly;
    rgb_t              rgb_d, rgb_q;
    logic [2:0]        sync_d, sync_q;

    fsm_state_e        state_d, state_q;
    logic [2:0]        shift_d, shift_q;
    logic              fade_d, fade_q;
    logic              gso_prev_q, vs_prev_q;
    logic              gso_rise, gso_fall, vs_fall;

    // Stage A
    always_comb begin
        rom_addr_d = bus.is_obj ? bus.Obj_address : '0;
        pix_in     = '{is_obj: bus.is_obj, bg: bus.Bg_rgb,
                       blank: bus.blank_in, hs: bus.hs_in, vs: bus.vs_in};
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rom_addr_q <= '0;
        end else begin
            rom_addr_q <= rom_addr_d;
        end
    end

    // Stage A capture plus ROM_LAT stages, so pix_dly lines up with rom_data
    sideband_delay #(
        .WIDTH  ($bits(pix_t)),
        .DEPTH  (ROM_LAT + 1),
        .RST_VAL(PIX_RST)
    ) u_sideband_delay (
        .clk  (Clk),
        .rst_n(Reset_n),
        .d    (pix_in),
        .q    (pix_dly)
    );

    // Stage C
    always_comb begin
        rgb_d  = dim_rgb(pix_dly.bg, shift_q);
        if (pix_dly.is_obj && (bus.rom_data != TRANSPARENT_IDX)) begin
            rgb_d = PALETTE[bus.rom_data];
        end
        sync_d = {pix_dly.blank, pix_dly.hs, pix_dly.vs};
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rgb_q  <= '0;
            sync_q <= {PIX_RST.blank, PIX_RST.hs, PIX_RST.vs};
        end else begin
            rgb_q  <= rgb_d;
            sync_q <= sync_d;
        end
    end

    assign gso_rise = bus.Game_Start_On & ~gso_prev_q;
    assign gso_fall = ~bus.Game_Start_On & gso_prev_q;
    assign vs_fall  = vs_prev_q & ~bus.vs_in;

    // Mode change is resolved first; a coincident frame edge then acts on the new state
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        fade_d  = fade_q;

        if (gso_rise) begin
            state_d = ST_SHOW;
            fade_d  = 1'b0;
        end else if (gso_fall && (state_q == ST_SHOW)) begin
            if (DIM_INIT == 3'd0) begin
                state_d = ST_PLAY;
                fade_d  = 1'b1;
            end else begin
                state_d = ST_BRIGHTEN;
            end
        end

        if (vs_fall) begin
            unique case (state_d)
                ST_SHOW: shift_d = DIM_INIT;
                ST_BRIGHTEN: begin
                    shift_d = (shift_q == 3'd0) ? 3'd0 : shift_q - 3'd1;
                    if (shift_d == 3'd0) begin
                        state_d = ST_PLAY;
                        fade_d  = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= ST_SHOW;
            shift_q    <= DIM_INIT;
            fade_q     <= 1'b0;
            gso_prev_q <= 1'b0;
            vs_prev_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            fade_q     <= fade_d;
            gso_prev_q <= bus.Game_Start_On;
            vs_prev_q  <= bus.vs_in;
        end
    end

    assign bus.rom_addr  = rom_addr_q;
    assign bus.Red       = rgb_q.r;
    assign bus.Green     = rgb_q.g;
    assign bus.Blue      = rgb_q.b;
    assign bus.blank_out = sync_q[2];
    assign bus.hs_out    = sync_q[1];
    assign bus.vs_out    = sync_q[0];
    assign bus.Fade_Done = fade_q;
endmodule

// File: doc/title_pixel_compositor.md
Name: title_pixel_compositor

Overview:
- Consumer side of the title-overlay interface: takes the overlay's per-pixel hit flag and sprite ROM address, reads the title ROM, maps palette indices to RGB, and composites over the game background before the VGA output.
- Also dims the background while the title is showing, then brightens it frame by frame once the game starts.
- Sits between the overlay/background generators and the VGA DAC. All sidebands are delayed to match pixel latency.

Parameters:
- ROM_LAT, 2, title ROM read latency in cycles (1..4)
- ADDR_W, 18, ROM address width
- BG_DIM, 2, background right-shift applied while the title is shown (0..7)

Ports:
- Clk  in  1  pixel clock
- Reset_n  in  1  asynchronous active-low reset
- Game_Start_On  in  1  title-screen active level from the overlay
- is_obj  in  1  current pixel lies inside the title box
- Obj_address  in  ADDR_W  title ROM address for the current pixel
- Bg_rgb  in  24  background colour for the current pixel {R,G,B}
- blank_in, hs_in, vs_in  in  1 each  VGA sidebands aligned with the inputs
- rom_addr  out  ADDR_W  registered ROM address
- rom_data  in  4  palette index, valid ROM_LAT cycles after rom_addr
- Red, Green, Blue  out  8 each  composited pixel
- blank_out, hs_out, vs_out  out  1 each  sidebands delayed by PIPE
- Fade_Done  out  1  high once the background has reached full brightness after start

Behaviour:
- Pipeline latency PIPE = ROM_LAT+2 cycles from any input pixel to its output pixel.
  - Stage A: register Obj_address into rom_addr; capture is_obj and Bg_rgb.
  - ROM_LAT stages: is_obj, Bg_rgb and sidebands ride a matching shift register.
  - Stage C: palette lookup plus mux into output registers.
- rom_addr is forced to 0 when is_obj=0, to limit ROM toggling.
- Compositing: if the delayed is_obj=1 and rom_data≠0, output PALETTE[rom_data]. Otherwise output the background, each channel >> cur_shift, zero-filled. Index 0 is transparent.
- FSM states: SHOW, BRIGHTEN, PLAY.
  - Reset: SHOW, cur_shift=BG_DIM, Fade_Done=0, all outputs 0, blank_out=0, hs_out=vs_out=1 (sync idle high).
  - SHOW -> BRIGHTEN on a Game_Start_On falling edge (registered previous value).
  - BRIGHTEN: on each vs_in falling edge (frame start), cur_shift decrements. When cur_shift reaches 0 -> PLAY and Fade_Done=1.
  - BRIGHTEN/PLAY -> SHOW on a Game_Start_On rising edge. cur_shift is reloaded to BG_DIM at the next vs_in falling edge, not mid-frame; Fade_Done clears immediately.
  - BG_DIM=0: SHOW -> PLAY directly on the falling edge; Fade_Done=1 in the next cycle.
- cur_shift only ever changes on a vs_in falling edge, so there is no mid-frame tearing.
- Falling and rising edges of Game_Start_On in the same frame are handled in order, with the state tracking the last edge. A vs edge coincident with a Game_Start_On edge: apply the state transition first; the shift update uses the new state.
- Reset assertion mid-frame clears all pipeline registers immediately. Output stays at reset values until PIPE cycles after deassertion.
- Colour channel arithmetic is unsigned 8-bit; no saturation is needed.

Decomposition:
- Package title_pkg:
  - rgb_t struct {r,g,b: 8 bits}
  - 16-entry PALETTE constant array
  - fsm state enum
  - TRANSPARENT_IDX=0
- One sub-module: sideband_delay (parameterised width/depth shift register, async reset to a per-bit reset value). Used for the is_obj/Bg_rgb/sync pipeline.

Test Plan:
- Reset mid-stream: Reset_n low for 3 cycles -> RGB=0, hs_out=vs_out=1, state SHOW, cur_shift=2.
- Latency check, ROM_LAT=2: is_obj=1, Obj_address=0x00123, ROM returns 5 -> rom_addr=0x00123 one cycle later; RGB=PALETTE[5] exactly 4 cycles after input; sidebands shifted by 4.
- Transparency: is_obj=1, rom_data=0, Bg_rgb=0x80C040 in SHOW -> output 0x203010. Same pixel in PLAY -> 0x80C040.
- Brighten sequence, BG_DIM=2: Game_Start_On 1->0 mid-frame -> shift stays 2 until the next vs_in falling edge, then 1, then 0. Fade_Done rises in the cycle after the second frame edge.
- Restart: in PLAY, Game_Start_On 0->1 mid-frame -> Fade_Done=0 next cycle; shift stays 0 until the next vs edge, then 2.
- is_obj=0 with Obj_address=0x3FFFF -> rom_addr=0; background passes through.
